// File: rtl/nor_bank.sv
// Bank of WIDTH FANIN-input NOR gates, sampled on falling clk, presented on rising clk; optional monitor (NOR_BANK_MONITOR_EN).
// Latency: half a cycle from the falling-edge sample to y; 1.5 cycles worst case for an input change.
// Backpressure: none; en=0 freezes the pending sample, clr restarts toggle and settle tracking.
module nor_bank #(
    parameter int              WIDTH  = 1,
    parameter int              FANIN  = 2,
    parameter logic [WIDTH-1:0] IV    = '0,
    parameter int              SETTLE = 4,
    parameter int              CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH*FANIN-1:0] a,
    input  logic                   en,
    input  logic                   clr,
    output logic [WIDTH-1:0]       y,
    output logic                   changed,
    output logic                   settled,
    output logic [CNT_W-1:0]       toggles
);

    logic [WIDTH-1:0] nor_val;
    logic [WIDTH-1:0] nxt;

    always_comb begin
        nor_val = '0;
        for (int i = 0; i < WIDTH; i++) begin
            nor_val[i] = ~|a[i*FANIN +: FANIN];
        end
    end

    // Falling-edge sample gives the two-phase evaluation that keeps feedback loops race-free.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nxt <= IV;
        end else if (en) begin
            nxt <= nor_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y <= IV;
        end else begin
            y <= nxt;
        end
    end

`ifdef NOR_BANK_MONITOR_EN

    localparam int PC_W  = $clog2(WIDTH + 1);
    localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
    localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};
    localparam logic [7:0] SETTLE_C = 8'(SETTLE);

    logic [WIDTH-1:0] diff;
    logic [PC_W-1:0]  pc;
    logic [SUM_W-1:0] sum;
    logic [CNT_W-1:0] tog_next;
    logic [7:0]       sc;
    logic [7:0]       sc_next;

    assign diff = nxt ^ y;

    always_comb begin
        pc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pc = pc + PC_W'(diff[i]);
        end
    end

    // Saturate on the widened sum so a large popcount can never wrap the counter.
    always_comb begin
        sum      = SUM_W'(toggles) + SUM_W'(pc);
        tog_next = (sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : sum[CNT_W-1:0];
    end

    always_comb begin
        sc_next = sc;
        if (|diff) begin
            sc_next = '0;
        end else if (sc < SETTLE_C) begin
            sc_next = sc + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            changed <= 1'b0;
            settled <= 1'b0;
            toggles <= '0;
            sc      <= '0;
        end else begin
            changed <= |diff;
            if (clr) begin
                toggles <= '0;
                sc      <= '0;
                settled <= 1'b0;
            end else begin
                toggles <= tog_next;
                sc      <= sc_next;
                settled <= (sc_next == SETTLE_C);
            end
        end
    end

`else

    logic unused_clr;
    assign unused_clr = clr;

    assign changed = 1'b0;
    assign settled = 1'b1;
    assign toggles = '0;

`endif

endmodule

// File: doc/nor_bank.md
# nor_bank

Parametrised bank of WIDTH independent FANIN-input NOR gates for the FPGA build of the AGC logic simulation. Each gate's inputs are sampled on the falling clock edge and its output is presented on the next rising edge, giving two-phase, race-free evaluation of NOR networks with combinational feedback. An optional stability monitor counts output toggles and flags when the bank has stopped changing, so benches and the top level can detect settled logic or oscillating loops.

## Interface
Parameters:
- WIDTH, 1, number of NOR gates (channels).
- FANIN, 2, inputs per gate (≥1; FANIN=1 is an inverter).
- IV, 0, WIDTH-bit reset value of y; bit i is the reset value of gate i.
- SETTLE, 4, consecutive no-change rising edges needed to assert settled (1..255).
- CNT_W, 16, width of the toggle counter.

Ports:
- clk  in  1  system clock; sample on falling edge, update on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- a  in  WIDTH*FANIN  gate inputs; gate i uses a[i*FANIN +: FANIN].
- en  in  1  sample enable, checked on the falling edge; 0 holds the pending value.
- clr  in  1  synchronous clear of toggles and the settle counter, taken on the rising edge.
- y  out  WIDTH  gate outputs.
- changed  out  1  high for one cycle after a rising edge on which any y bit changed.
- settled  out  1  no y change for SETTLE consecutive rising edges.
- toggles  out  CNT_W  saturating count of individual y-bit transitions.

## Operation
- Falling edge: if en=1, nxt[i] = ~|a[i*FANIN +: FANIN] for every i; if en=0, nxt holds its value.
- Rising edge: y <= nxt; changed <= |(nxt ^ y).
- Only one pending register (nxt) exists; multiple input changes within a cycle collapse to the value present at the falling edge.
- Reset (rst_n=0, any time, independent of clk):
  - y=IV, nxt=IV, changed=0, settled=0, toggles=0, settle counter=0.
  - A falling edge in the first half-cycle after release samples normally.
  - Reset mid-cycle discards any pending nxt.
- Monitor (settle counter sc, 8 bits):
  - On a rising edge with any y change: sc=0, settled=0.
  - On a rising edge with no change: sc=min(sc+1, SETTLE); settled=1 when sc reaches SETTLE.
- toggles: each rising edge adds popcount(nxt ^ y), saturating at 2^CNT_W−1 and never wrapping.
- clr=1 on a rising edge: toggles=0 and sc=0, settled=0. This takes priority over any toggles counted on the same edge. y and changed update normally.
- Width rules:
  - The popcount adder is wide enough for WIDTH.
  - Saturation is checked on the full-width sum before truncation.

## Timing
- Latency: input stable before a falling edge reaches y at the following rising edge (half cycle). The worst case for an input change just after a falling edge is 1.5 cycles.
- changed, settled and toggles are registered on the same rising edge as y and reflect that edge's transition.
- en and a have setup/hold requirements to the falling edge only; clr has them to the rising edge only.
- Reset assertion is asynchronous. Deassertion must be synchronised externally to the rising edge.

## Configuration
- NOR_BANK_MONITOR_EN defined: the settle counter, settled, changed and toggles are implemented as described.
- NOR_BANK_MONITOR_EN undefined:
  - No monitor logic is built.
  - changed=0, toggles=0, settled=1 constantly; clr is ignored.
  - y behaviour is identical in both builds.

## Test plan
- Reset: WIDTH=4, FANIN=2, IV=4'b1010. Hold rst_n=0 with clock running -> y=1010, toggles=0, settled=0, changed=0. Release with a=0 -> y=1111 at the first rising edge after the next falling edge; toggles=2.
- Function: sweep every FANIN=3 input combination on one channel -> y=1 only for 000, appearing half a cycle after each falling edge; changed pulses exactly on the edges where y flips.
- Hold: set en=0, change a -> y frozen. Set en=1 -> new value appears at the next rising edge; a pulse on a that falls between falling edges is never seen.
- Settle/oscillation:
  - SETTLE=4, a static -> settled=1 on the 4th unchanged rising edge.
  - FANIN=1 inverter with y fed back to a -> y toggles every cycle, settled stays 0, toggles increments by 1 per cycle.
- Saturation/clr: CNT_W=3 with the oscillating loop -> toggles stops at 7. clr on the same edge as a toggle -> toggles=0, then 1 on the next edge.
- Async reset mid-operation: drop rst_n between a falling and a rising edge with a new value pending -> y=IV immediately, and the pending value is never output.
